// File: rtl/apu_if_pkg.sv
// Shared types for the APU request initiator.
// Response record, request FSM states and credit-width helper.
package apu_if_pkg;

  localparam int APU_ID_W     = 9;
  localparam int APU_DATA_W   = 32;
  localparam int APU_RFLAGS_W = 5;

  typedef struct packed {
    logic [APU_DATA_W-1:0]   data;
    logic [APU_RFLAGS_W-1:0] flags;
    logic [APU_ID_W-1:0]     id;
  } apu_rsp_t;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } req_state_e;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/apu_rsp_fifo.sv
// Registered response FIFO; a pop frees a slot for a same-cycle write.
// Writes into a full FIFO are dropped and flagged sticky.
module apu_rsp_fifo
  import apu_if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = apu_rsp_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_en && !push)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/apu_req_initiator.sv
// Core-side APU master: held request toward the FPU, credit-bounded
// outstanding ops, and a response buffer drained by the core.
module apu_req_initiator
  import apu_if_pkg::*;
#(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 2,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req_valid_i,
  output logic                          core_req_ready_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       core_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     core_flags_i,
  input  logic [ID_WIDTH-1:0]           core_id_i,
  output logic                          apu_req_o,
  input  logic                          apu_gnt_i,
  output logic [ID_WIDTH-1:0]           apu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
  output logic [OPCODE_WIDTH-1:0]       apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
  output logic                          apu_rready_o,
  input  logic                          apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
  input  logic [ID_WIDTH-1:0]           apu_rID_i,
  output logic                          core_rsp_valid_o,
  input  logic                          core_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         core_rsp_data_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    core_rsp_flags_o,
  output logic [ID_WIDTH-1:0]           core_rsp_id_o,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int CW = credit_w(RSP_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [FLAGS_OUT_WIDTH-1:0] flags;
    logic [ID_WIDTH-1:0]        id;
  } rsp_t;

  req_state_e    state;
  logic          accept;
  logic          pop;
  logic          inc;
  logic          dec;
  rsp_t          wr_rsp;
  rsp_t          rd_rsp;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign core_req_ready_o = (state == ST_IDLE || apu_gnt_i)
                         && (outstanding_o < CW'(RSP_DEPTH));
  assign accept = core_req_valid_i && core_req_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      apu_req_o      <= 1'b0;
      apu_ID_o       <= '0;
      apu_operands_o <= '0;
      apu_op_o       <= '0;
      apu_flags_o    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_REQ;
            apu_req_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (apu_gnt_i && !accept) begin
            state     <= ST_IDLE;
            apu_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          apu_req_o <= 1'b0;
        end
      endcase
      if (accept) begin
        apu_ID_o       <= core_id_i;
        apu_operands_o <= core_operands_i;
        apu_op_o       <= core_op_i;
        apu_flags_o    <= core_flags_i;
      end
    end
  end

  // Clamp at zero: responses arriving after a reset still get popped.
  assign pop = core_rsp_valid_o && core_rsp_ready_i;
  assign inc = accept;
  assign dec = pop && (outstanding_o != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o <= '0;
    end else begin
      unique case (1'b1)
        inc && !dec: outstanding_o <= outstanding_o + CW'(1);
        dec && !inc: outstanding_o <= outstanding_o - CW'(1);
        default:     outstanding_o <= outstanding_o;
      endcase
    end
  end

  assign busy_o       = (outstanding_o != '0);
  assign apu_rready_o = 1'b1;

  assign wr_rsp.data  = apu_rdata_i;
  assign wr_rsp.flags = apu_rflags_i;
  assign wr_rsp.id    = apu_rID_i;

  apu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (apu_rvalid_i),
    .wr_data  (wr_rsp),
    .rd_en    (core_rsp_ready_i),
    .rd_data  (rd_rsp),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow_o)
  );

  assign core_rsp_valid_o = !fifo_empty;
  assign core_rsp_data_o  = rd_rsp.data;
  assign core_rsp_flags_o = rd_rsp.flags;
  assign core_rsp_id_o    = rd_rsp.id;

  logic unused_fifo;
  assign unused_fifo = fifo_full ^ (|fifo_count);

endmodule
